// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared state codes, round count and key-schedule shift tables
package des_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int         ROUNDS     = 16;
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef logic [15:0][1:0] shift_tab_t;

    // Entries listed from round 15 down to round 0.
    localparam shift_tab_t ENC_SHIFT = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
                                        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
    // Decrypt starts from C16/D16 == C0/D0, so round 0 uses K16 without rotating.
    localparam shift_tab_t DEC_SHIFT = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
                                        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

    function automatic logic [3:0] key_index(input logic [3:0] round_idx, input logic decrypt);
        return decrypt ? (LAST_ROUND - round_idx) : round_idx;
    endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// rtl/des_round_ctrl_if.sv - request and datapath-strobe bundle of the DES round sequencer
interface des_round_ctrl_if;

    logic       start;
    logic       decrypt;
    logic       abort;
    logic       busy;
    logic       load_en;
    logic       round_en;
    logic [1:0] shift_amt;
    logic       shift_right;
    logic       out_en;
    logic       done;
    logic [3:0] round_idx;
    logic [3:0] key_idx;
    logic       mode_q;

    modport master (
        output start, decrypt, abort,
        input  busy, load_en, round_en, shift_amt, shift_right,
               out_en, done, round_idx, key_idx, mode_q
    );

    modport slave (
        input  start, decrypt, abort,
        output busy, load_en, round_en, shift_amt, shift_right,
               out_en, done, round_idx, key_idx, mode_q
    );

endinterface

// File: rtl/des_shift_sched.sv
// rtl/des_shift_sched.sv - per-round C/D rotate amount and direction lookup
module des_shift_sched
    import des_pkg::*;
(
    input  logic       i_en,
    input  logic [3:0] i_round_idx,
    input  logic       i_decrypt,
    output logic [1:0] o_shift_amt,
    output logic       o_shift_right
);

    // Table lookup, forced to no-rotate when no round is being executed
    always_comb begin
        o_shift_amt   = 2'd0;
        o_shift_right = 1'b0;
        if (i_en) begin
            o_shift_right = i_decrypt;
            o_shift_amt   = i_decrypt ? DEC_SHIFT[i_round_idx] : ENC_SHIFT[i_round_idx];
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - load / 16-round / final-permutation sequencer for the DES datapath
module des_round_ctrl
    import des_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    des_round_ctrl_if.slave bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_start_q;
    logic       r_mode_q;
    logic [3:0] r_round_idx;
    logic       w_start_edge;
    logic       w_accept;
    logic       w_in_round;

    assign w_start_edge = bus.start & ~r_start_q;
    assign w_accept     = (r_state == S_IDLE) && w_start_edge && !bus.abort;
    assign w_in_round   = (r_state == S_ROUND);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state decode; abort overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_ROUND;
            S_ROUND: if (r_round_idx == LAST_ROUND) w_next_state = S_FINAL;
            S_FINAL: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (bus.abort) w_next_state = S_IDLE;
    end

    // Start edge detector, latched mode and round counter (wraps to 0 after the last round)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q   <= 1'b0;
            r_mode_q    <= 1'b0;
            r_round_idx <= 4'd0;
        end else begin
            r_start_q <= bus.start;
            if (bus.abort) begin
                r_round_idx <= 4'd0;
            end else if (w_accept) begin
                r_mode_q    <= bus.decrypt;
                r_round_idx <= 4'd0;
            end else if (w_in_round) begin
                r_round_idx <= r_round_idx + 4'd1;
            end
        end
    end

    des_shift_sched u_shift_sched (
        .i_en          (w_in_round),
        .i_round_idx   (r_round_idx),
        .i_decrypt     (r_mode_q),
        .o_shift_amt   (bus.shift_amt),
        .o_shift_right (bus.shift_right)
    );

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.load_en   = (r_state == S_LOAD);
    assign bus.round_en  = w_in_round;
    assign bus.out_en    = (r_state == S_FINAL);
    assign bus.done      = (r_state == S_DONE);
    assign bus.round_idx = r_round_idx;
    assign bus.key_idx   = key_index(r_round_idx, r_mode_q);
    assign bus.mode_q    = r_mode_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// tb/tb_des_round_ctrl.sv - directed self-checking bench for des_round_ctrl
module tb_des_round_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int enc_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_tab [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_round_ctrl_if bus ();

    des_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.abort   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.load_en, bus.round_en, bus.out_en, bus.done, bus.shift_amt,
             bus.shift_right, bus.round_idx, bus.key_idx, bus.mode_q} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=0", {bus.busy, bus.load_en,
                     bus.round_en, bus.out_en, bus.done, bus.shift_amt, bus.shift_right,
                     bus.round_idx, bus.key_idx, bus.mode_q});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_encrypt();
        logic [4:0] exp_ctl;
        int sum = 0;
        bus.decrypt = 1'b0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp_ctl = {c <= 19, c == 1, c >= 2 && c <= 17, c == 18, c == 19};
            checks++;
            if ({bus.busy, bus.load_en, bus.round_en, bus.out_en, bus.done} !== exp_ctl) begin
                errors++;
                $display("FAIL enc_ctl cycle=%0d actual=%b required=%b", c,
                         {bus.busy, bus.load_en, bus.round_en, bus.out_en, bus.done}, exp_ctl);
            end
            if (c >= 2 && c <= 17) begin
                sum += int'(bus.shift_amt);
                checks++;
                if (bus.shift_amt !== 2'(enc_tab[c-2]) || bus.shift_right !== 1'b0 ||
                    bus.round_idx !== 4'(c-2) || bus.key_idx !== 4'(c-2)) begin
                    errors++;
                    $display("FAIL enc_round cycle=%0d actual amt=%0d right=%b idx=%0d key=%0d required amt=%0d right=0 idx=%0d key=%0d",
                             c, bus.shift_amt, bus.shift_right, bus.round_idx, bus.key_idx,
                             enc_tab[c-2], c-2, c-2);
                end
            end else begin
                checks++;
                if (bus.shift_amt !== 2'd0 || bus.shift_right !== 1'b0) begin
                    errors++;
                    $display("FAIL enc_noshift cycle=%0d actual amt=%0d right=%b required 0 0",
                             c, bus.shift_amt, bus.shift_right);
                end
            end
        end
        checks++;
        if (sum != 28) begin
            errors++;
            $display("FAIL enc_shift_sum actual=%0d required=28", sum);
        end
    endtask

    task automatic test_decrypt();
        logic [4:0] exp_ctl;
        bus.decrypt = 1'b1;
        bus.start   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp_ctl = {c <= 19, c == 1, c >= 2 && c <= 17, c == 18, c == 19};
            checks++;
            if ({bus.busy, bus.load_en, bus.round_en, bus.out_en, bus.done} !== exp_ctl ||
                bus.mode_q !== 1'b1) begin
                errors++;
                $display("FAIL dec_ctl cycle=%0d actual=%b mode=%b required=%b mode=1", c,
                         {bus.busy, bus.load_en, bus.round_en, bus.out_en, bus.done},
                         bus.mode_q, exp_ctl);
            end
            if (c >= 2 && c <= 17) begin
                checks++;
                if (bus.shift_amt !== 2'(dec_tab[c-2]) || bus.shift_right !== 1'b1 ||
                    bus.key_idx !== 4'(17-c)) begin
                    errors++;
                    $display("FAIL dec_round cycle=%0d actual amt=%0d right=%b key=%0d required amt=%0d right=1 key=%0d",
                             c, bus.shift_amt, bus.shift_right, bus.key_idx, dec_tab[c-2], 17-c);
                end
            end
        end
        bus.decrypt = 1'b0;
    endtask

    task automatic test_abort();
        int n_out = 0;
        int n_done = 0;
        bus.decrypt = 1'b0;
        bus.start   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.round_idx !== 4'd7 || bus.round_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup actual idx=%0d round_en=%b required idx=7 round_en=1",
                     bus.round_idx, bus.round_en);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.round_idx !== 4'd0 || bus.round_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle actual busy=%b idx=%0d round_en=%b required 0 0 0",
                     bus.busy, bus.round_idx, bus.round_en);
        end
        repeat (15) begin
            @(negedge clk);
            n_out  += int'(bus.out_en);
            n_done += int'(bus.done);
        end
        checks++;
        if (n_out != 0 || n_done != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet actual out_en=%0d done=%0d busy=%b required 0 0 0",
                     n_out, n_done, bus.busy);
        end
        bus.start = 1'b1;
        n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                checks++;
                if (c != 19) begin
                    errors++;
                    $display("FAIL abort_rerun_done_cycle actual=%0d required=19", c);
                end
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL abort_rerun_done_count actual=%0d required=1", n_done);
        end
    endtask

    task automatic test_start_held();
        int n_load = 0;
        int n_done = 0;
        bus.start = 1'b1;
        repeat (50) begin
            @(negedge clk);
            n_load += int'(bus.load_en);
            n_done += int'(bus.done);
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_load != 1 || n_done != 1) begin
            errors++;
            $display("FAIL start_held actual loads=%0d dones=%0d required 1 1", n_load, n_done);
        end
    endtask

    task automatic test_toggle_busy();
        int n_load = 0;
        int n_done = 0;
        bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            n_load += int'(bus.load_en);
            n_done += int'(bus.done);
            bus.start = (c >= 3 && c <= 15) ? ~bus.start : 1'b0;
        end
        checks++;
        if (n_load != 1 || n_done != 1) begin
            errors++;
            $display("FAIL toggle_busy actual loads=%0d dones=%0d required 1 1", n_load, n_done);
        end
    endtask

    task automatic test_mode_change();
        bus.decrypt = 1'b1;
        bus.start   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 3) bus.decrypt = 1'b0;
            if (c >= 4 && c <= 17) begin
                checks++;
                if (bus.mode_q !== 1'b1 || bus.shift_right !== 1'b1 ||
                    bus.shift_amt !== 2'(dec_tab[c-2]) || bus.key_idx !== 4'(17-c)) begin
                    errors++;
                    $display("FAIL mode_hold cycle=%0d actual mode=%b right=%b amt=%0d key=%0d required 1 1 %0d %0d",
                             c, bus.mode_q, bus.shift_right, bus.shift_amt, bus.key_idx,
                             dec_tab[c-2], 17-c);
                end
            end
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.load_en !== 1'b1 || bus.mode_q !== 1'b0) begin
            errors++;
            $display("FAIL mode_relatch actual load=%b mode=%b required 1 0", bus.load_en, bus.mode_q);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rst_mid();
        bus.decrypt = 1'b1;
        bus.start   = 1'b1;
        repeat (6) @(negedge clk);
        bus.decrypt = 1'b0;
        checks++;
        if (bus.round_en !== 1'b1 || bus.mode_q !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup actual round_en=%b mode=%b required 1 1", bus.round_en, bus.mode_q);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.load_en, bus.round_en, bus.out_en, bus.done, bus.shift_amt,
             bus.shift_right, bus.round_idx, bus.key_idx, bus.mode_q} !== 18'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs actual=%b required=0", {bus.busy, bus.load_en,
                     bus.round_en, bus.out_en, bus.done, bus.shift_amt, bus.shift_right,
                     bus.round_idx, bus.key_idx, bus.mode_q});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.load_en !== 1'b1 || bus.mode_q !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_high actual load=%b mode=%b required 1 0", bus.load_en, bus.mode_q);
        end
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_abort_start_idle();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.load_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_idle actual busy=%b load=%b required 0 0", bus.busy, bus.load_en);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_no_late_edge actual busy=%b required 0", bus.busy);
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_abort();
        test_start_held();
        test_toggle_busy();
        test_mode_change();
        test_rst_mid();
        test_abort_start_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
